// File: rtl/serial_pkg.sv
// Shared definitions for the serial I/O blocks: state encoding and bit-timing helpers.
package serial_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      WAIT  = 3'd4
   } rx_state_t;

   // Full bit period in clocks for a given timer width.
   function automatic int bit_period(input int tw);
      return 1 << tw;
   endfunction

   // Half bit period: offset from the start edge to the bit centre.
   function automatic int half_period(input int tw);
      return 1 << (tw - 1);
   endfunction

   // Bits needed to hold values 0..n-1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/serial_rx_sync2.sv
// Two-flop synchroniser for asynchronous inputs; resets to RstVal.
module sync2 #(
   parameter logic RstVal = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two stages so a metastable first flop settles before anyone uses q.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= RstVal;
         q    <= RstVal;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/serial_rx.sv
// Asynchronous serial receiver: centre-samples an idle-high line, checks start/stop,
// deserialises Width bits LSB first and hands words out through valid/ack.
module serial_rx
   import serial_pkg::*;
#(
   parameter int Width      = 8,
   parameter int TimerWidth = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx,
   input  logic             ack,
   output logic [Width-1:0] D,
   output logic             valid,
   output logic             ferr,
   output logic             overrun
);

   localparam int CW = clog2(Width + 1);
   localparam logic [TimerWidth-1:0] TLAST = TimerWidth'(bit_period(TimerWidth) - 1);
   localparam logic [TimerWidth-1:0] HLAST = TimerWidth'(half_period(TimerWidth) - 1);
   localparam logic [CW-1:0]         BLAST = CW'(Width - 1);

   rx_state_t              state, nstate;
   logic                   rxs;
   logic [TimerWidth-1:0]  timer;
   logic [CW-1:0]          bitcnt;
   logic [Width-1:0]       sr;
   logic                   tmr_clr, cnt_clr, shift, load, ferr_set;

   sync2 #(.RstVal(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rxs)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nstate;
   end

   // Next state and datapath strobes; all sampling happens when the timer reaches a bit centre.
   always_comb begin
      nstate   = state;
      tmr_clr  = 1'b0;
      cnt_clr  = 1'b0;
      shift    = 1'b0;
      load     = 1'b0;
      ferr_set = 1'b0;
      case (state)
         IDLE: begin
            if (!rxs) begin
               nstate  = START;
               tmr_clr = 1'b1;
            end
         end
         START: begin
            if (timer == HLAST) begin
               if (!rxs) begin
                  nstate  = DATA;
                  tmr_clr = 1'b1;
                  cnt_clr = 1'b1;
               end else begin
                  nstate = IDLE;   // start bit did not survive to its centre: glitch
               end
            end
         end
         DATA: begin
            if (timer == TLAST) begin
               shift = 1'b1;
               if (bitcnt == BLAST) nstate = STOP;
            end
         end
         STOP: begin
            if (timer == TLAST) begin
               if (rxs) begin
                  load   = 1'b1;
                  nstate = IDLE;
               end else begin
                  ferr_set = 1'b1;
                  nstate   = WAIT;
               end
            end
         end
         WAIT: begin
            if (rxs) nstate = IDLE;   // hold off until the break ends
         end
         default: nstate = IDLE;
      endcase
   end

   // Bit timer wraps naturally at T, so DATA/STOP need no explicit reload.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         timer <= '0;
      else if (tmr_clr) timer <= '0;
      else              timer <= timer + TimerWidth'(1);
   end

   // Data bit counter and LSB-first shift register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bitcnt <= '0;
         sr     <= '0;
      end else begin
         if (cnt_clr)    bitcnt <= '0;
         else if (shift) bitcnt <= bitcnt + CW'(1);
         if (shift)      sr <= {rxs, sr[Width-1:1]};
      end
   end

   // Output word, handshake and error flags; a load in the same cycle as ack wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         D       <= '0;
         valid   <= 1'b0;
         ferr    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         ferr <= ferr_set;
         if (load) begin
            D     <= sr;
            valid <= 1'b1;
            if (valid && ack)  overrun <= 1'b0;
            else if (valid)    overrun <= 1'b1;
         end else if (valid && ack) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: doc/serial_rx.md
# serial_rx

Asynchronous serial receiver that sits directly downstream of the serial transmitter and recovers the frames it emits. Samples an idle-high line, validates start and stop bits and deserialises Width data bits at a fixed bit period of 2^TimerWidth clocks. Presents each word through a valid/ack handshake and flags framing and overrun errors. Intended for loopback links and board-to-board links inside the genetic-hardware I/O layer.

## Interface
- Width, 8, data bits per frame
- TimerWidth, 8, bit period T = 2^TimerWidth clocks; half period H = 2^(TimerWidth-1); TimerWidth >= 2
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rx  in  1  serial line, idle high, asynchronous to clk
- ack  in  1  consumer has taken D; clears valid
- D  out  Width  received word, numeric LSB first on the line; holds its value until the next good frame
- valid  out  1  D holds an unconsumed word
- ferr  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  sticky: a good frame completed while valid was still high; cleared by ack

## Operation
- Reset (rst low, asynchronous) sets D=0, valid=0, ferr=0, overrun=0, state IDLE, timer=0, bit count=0, and both synchroniser flops to 1.
- rx passes through a 2-flop synchroniser; rxs is the second flop. All decisions use rxs.
- IDLE: on rxs=0, clear timer, go to START.
- START: after H cycles, sample rxs. If 0, clear timer and bit count and go to DATA. If 1 (glitch), go to IDLE with no outputs.
- DATA: every T cycles, sample rxs into the shift register. The first sample is bit 0 (LSB). After Width samples, go to STOP.
- STOP: T cycles after the last data sample, sample rxs.
  - 1: load D from the shift register, set valid, go to IDLE. If valid was already 1 and ack is not high in this cycle, set overrun. D is overwritten with the new word.
  - 0: pulse ferr, leave D/valid unchanged, go to WAIT.
- WAIT (break/line fault): remain until rxs=1, then go to IDLE.
- Handshake: ack high while valid=1 clears valid and overrun on the next edge. ack while valid=0 is ignored. If a load and an ack occur in the same cycle, the load wins (valid stays 1, overrun stays 0).
- Timer is TimerWidth bits, counts 0..T-1 and wraps. Bit count is clog2(Width+1) bits.
- The rx line may fall again immediately after the stop sample. IDLE detects it on the next cycle, so back-to-back frames are supported (the transmitter emits at least one stop bit).

## Timing
- Let cycle 0 be the first clk edge that samples rx=0.
- rxs low at edge 2.
- Start sample at edge 2+H.
- Data bit k sampled at edge 2+H+(k+1)·T.
- Stop sample at edge 2+H+(Width+1)·T. valid/ferr are visible after that edge.
- For Width=8, TimerWidth=4: valid rises after edge 154. A 1-cycle-late tolerant window is acceptable in the bench.
- Sampling at the bit centre tolerates ±H-1 cycles of cumulative drift across a frame.
- valid has no combinational path from ack; all outputs are registered.

## Structure
- Shared package serial_pkg holds:
  - the state encoding (IDLE, START, DATA, STOP, WAIT)
  - the helper for T and H, for reuse by the transmitter
  - clog2
- One sub-module is natural: sync2 (2-flop synchroniser, active-low async reset to parameterised value 1). Reuse it for any asynchronous input in the I/O layer.

## Test plan
- Width=8, TimerWidth=4. Drive a frame of 0xA5 with T=16 → valid=1 and D=0xA5 at edge 154, ferr=0. ack for 1 cycle → valid=0 next edge.
- Loopback with the existing transmitter, sending 0x00, 0xFF, 0x3C back-to-back → three good words in order, no ferr, overrun=0 when acked within 1 frame.
- 4-cycle low glitch on idle rx → no valid, no ferr, state returns to IDLE by edge 2+H+1.
- Frame 0x55 with stop bit forced 0 and the line then held low for 40 cycles → single ferr pulse, valid unchanged, no new frame detected until rx returns high.
- Two good frames (0x11, then 0x22) with no ack → D=0x22, valid=1, overrun=1. Then ack → valid=0, overrun=0.
- Assert rst mid-DATA on frame 0x99 → all outputs 0 immediately. Release rst with the line idle, then send 0x42 → D=0x42 received correctly.
